// File: rtl/sync_long_window_ctrl.sv
// Long-preamble timing controller: runs the peak-search window, turns the peak index
// into the first data-symbol boundary, then forwards FFT_LEN-sample windows and drops each CP.
module sync_long_window_ctrl #(
    parameter int GP_COUNTER_WIDTH = 8,
    parameter int SEARCH_LEN       = 96,
    parameter int FFT_LEN          = 64,
    parameter int CP_LEN           = 16,
    parameter int CORR_LAT         = 0,
    parameter int DATA_W           = 16
) (
    input  logic                        CLK,
    input  logic                        s_RST,
    input  logic                        enable,
    input  logic [7:0]                  n_sym,
    input  logic                        in_strobe,
    input  logic [DATA_W-1:0]           in_I,
    input  logic [DATA_W-1:0]           in_Q,
    output logic [GP_COUNTER_WIDTH-1:0] Counter_Val,
    output logic                        search_active,
    input  logic [GP_COUNTER_WIDTH-1:0] peak_Index,
    output logic [DATA_W-1:0]           out_I,
    output logic [DATA_W-1:0]           out_Q,
    output logic                        out_strobe,
    output logic                        symbol_start,
    output logic [5:0]                  sample_idx,
    output logic [7:0]                  sym_count,
    output logic                        sync_fail,
    output logic                        busy
);
    localparam int SW      = GP_COUNTER_WIDTH + 1;
    localparam int TW      = GP_COUNTER_WIDTH + 2;
    localparam int CNT_MAX = (FFT_LEN > CP_LEN + 1) ? FFT_LEN : CP_LEN + 1;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);
    localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_LEN);
    localparam logic [SW-1:0]    S_MAX    = '1;
    localparam logic [SW-1:0]    S_END    = SW'(SEARCH_LEN);
    localparam logic [SW-1:0]    LAT_S    = SW'(CORR_LAT);
    localparam logic [TW-1:0]    LAT_T    = TW'(CORR_LAT);
    localparam logic [TW-1:0]    TGT_OFS  = TW'(FFT_LEN + 1 + CP_LEN);

    typedef enum logic [2:0] {IDLE, SEARCH, LATCH, WAIT_START, WINDOW, GUARD, DONE, FAIL} state_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               s_q, s_d, s_inc;
    logic [TW-1:0]               tgt_q, tgt_d, tgt_calc;
    logic [SW-1:0]               lat_diff;
    logic [7:0]                  nsym_q, nsym_d, sym_q, sym_d, sym_inc;
    logic [CNT_W-1:0]            cnt_q, cnt_d, fwd_idx;
    logic [GP_COUNTER_WIDTH-1:0] cval_q, cval_d;
    logic [DATA_W-1:0]           oi_q, oi_d, oq_q, oq_d;
    logic                        ostb_q, ostb_d, sst_q, sst_d;
    logic [5:0]                  idx_q, idx_d;
    logic                        fwd, win_end, last_sym, latch_fail;

    // Peak index minus correlator latency; a borrow means the peak sits before the window.
    assign lat_diff   = {1'b0, peak_Index} - LAT_S;
    assign tgt_calc   = TW'(peak_Index) + TGT_OFS - LAT_T;
    assign s_inc      = (s_q == S_MAX) ? s_q : s_q + 1'b1;
    assign sym_inc    = sym_q + 8'd1;
    assign last_sym   = (nsym_q != 8'd0) && (sym_inc == nsym_q);
    assign latch_fail = lat_diff[SW-1] || (tgt_calc < TW'(s_d));

    always_ff @(posedge CLK) begin
        if (s_RST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = SEARCH;
            SEARCH:     if (s_d == S_END) state_d = LATCH;
            LATCH:      state_d = latch_fail ? FAIL : WAIT_START;
            WAIT_START, WINDOW, GUARD:
                if (fwd) state_d = !win_end ? WINDOW : (last_sym ? DONE : GUARD);
            default:    state_d = state_q;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_comb begin
        search_active = (state_q == SEARCH) || (state_q == LATCH);
        busy          = (state_q != IDLE);
        sync_fail     = (state_q == FAIL);
    end

    always_comb begin
        s_d     = s_q;
        tgt_d   = tgt_q;
        nsym_d  = nsym_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        cval_d  = cval_q;
        oi_d    = oi_q;
        oq_d    = oq_q;
        idx_d   = idx_q;
        ostb_d  = 1'b0;
        sst_d   = 1'b0;
        fwd     = 1'b0;
        fwd_idx = cnt_q;
        win_end = 1'b0;
        case (state_q)
            SEARCH: if (in_strobe) begin
                s_d    = s_inc;
                cval_d = GP_COUNTER_WIDTH'(s_q);
            end
            LATCH: begin
                if (in_strobe) s_d = s_inc;
                tgt_d  = tgt_calc;
                nsym_d = n_sym;
            end
            WAIT_START: if (in_strobe) begin
                s_d = s_inc;
                if (TW'(s_q) == tgt_q) begin
                    fwd     = 1'b1;
                    fwd_idx = '0;
                end
            end
            WINDOW: fwd = in_strobe;
            GUARD: if (in_strobe) begin
                if (cnt_q == CP_LAST) begin
                    fwd     = 1'b1;
                    fwd_idx = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Window position counter doubles as the CP discard counter in GUARD.
        if (fwd) begin
            ostb_d = 1'b1;
            sst_d  = (fwd_idx == '0);
            idx_d  = 6'(fwd_idx);
            oi_d   = in_I;
            oq_d   = in_Q;
            cnt_d  = fwd_idx + 1'b1;
            if (fwd_idx == LAST_IDX) begin
                win_end = 1'b1;
                cnt_d   = '0;
                sym_d   = sym_inc;
            end
        end
        if (!enable) begin
            s_d    = '0;
            tgt_d  = '0;
            nsym_d = '0;
            sym_d  = '0;
            cnt_d  = '0;
            cval_d = '0;
            oi_d   = '0;
            oq_d   = '0;
            idx_d  = '0;
            ostb_d = 1'b0;
            sst_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (s_RST) begin
            s_q    <= '0;
            tgt_q  <= '0;
            nsym_q <= '0;
            sym_q  <= '0;
            cnt_q  <= '0;
            cval_q <= '0;
            oi_q   <= '0;
            oq_q   <= '0;
            idx_q  <= '0;
            ostb_q <= 1'b0;
            sst_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            tgt_q  <= tgt_d;
            nsym_q <= nsym_d;
            sym_q  <= sym_d;
            cnt_q  <= cnt_d;
            cval_q <= cval_d;
            oi_q   <= oi_d;
            oq_q   <= oq_d;
            idx_q  <= idx_d;
            ostb_q <= ostb_d;
            sst_q  <= sst_d;
        end
    end

    assign Counter_Val  = cval_q;
    assign out_I        = oi_q;
    assign out_Q        = oq_q;
    assign out_strobe   = ostb_q;
    assign symbol_start = sst_q;
    assign sample_idx   = idx_q;
    assign sym_count    = sym_q;
endmodule

// File: tb/tb_sync_long_window_ctrl.sv
// Randomized bench for sync_long_window_ctrl: two instances (CORR_LAT 0 and 4) share stimulus;
// expected window samples are queued per instance and popped by negedge monitors.
module tb_sync_long_window_ctrl;
    localparam int SL = 96, FFT = 64, CP = 16, PER = FFT + CP;

    logic        CLK = 1'b0;
    logic        s_RST, enable, in_strobe;
    logic [7:0]  n_sym, peak_Index;
    logic [15:0] in_I, in_Q;

    logic [7:0]  a_cval, b_cval, a_symc, b_symc;
    logic [15:0] a_oi, a_oq, b_oi, b_oq;
    logic [5:0]  a_idx, b_idx;
    logic        a_sa, b_sa, a_ostb, b_ostb, a_sst, b_sst, a_fail, b_fail, a_busy, b_busy;

    sync_long_window_ctrl dut_a (
        .CLK(CLK), .s_RST(s_RST), .enable(enable), .n_sym(n_sym), .in_strobe(in_strobe),
        .in_I(in_I), .in_Q(in_Q), .Counter_Val(a_cval), .search_active(a_sa),
        .peak_Index(peak_Index), .out_I(a_oi), .out_Q(a_oq), .out_strobe(a_ostb),
        .symbol_start(a_sst), .sample_idx(a_idx), .sym_count(a_symc),
        .sync_fail(a_fail), .busy(a_busy));

    sync_long_window_ctrl #(.CORR_LAT(4)) dut_b (
        .CLK(CLK), .s_RST(s_RST), .enable(enable), .n_sym(n_sym), .in_strobe(in_strobe),
        .in_I(in_I), .in_Q(in_Q), .Counter_Val(b_cval), .search_active(b_sa),
        .peak_Index(peak_Index), .out_I(b_oi), .out_Q(b_oq), .out_strobe(b_ostb),
        .symbol_start(b_sst), .sample_idx(b_idx), .sym_count(b_symc),
        .sync_fail(b_fail), .busy(b_busy));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic [5:0]  idx;
        logic        st;
    } exp_t;

    exp_t qa[$], qb[$];
    int tests = 0, fails = 0;
    int sampled, lat_cyc;
    bit fail_a, fail_b;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : mon_a
        exp_t e;
        if (a_ostb) begin
            if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_window_sample", {a_oi, a_oq, a_idx, a_sst}, e);
            end
        end
    end

    always @(negedge CLK) begin : mon_b
        exp_t e;
        if (b_ostb) begin
            if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_window_sample", {b_oi, b_oq, b_idx, b_sst}, e);
            end
        end
    end

    // Position of sample n inside the symbol stream, or -1 if it is not forwarded.
    function automatic int win_pos(int n, int tgt, bit fl, int ns);
        int k;
        if (fl || n < tgt) return -1;
        k = n - tgt;
        if ((k % PER) >= FFT) return -1;
        if (ns != 0 && (k / PER) >= ns) return -1;
        return k % PER;
    endfunction

    function automatic int exp_sym(int tgt, bit fl, int nfed, int ns);
        int c;
        if (fl || (nfed - 1) < tgt + FFT - 1) return 0;
        c = (nfed - 1 - tgt - (FFT - 1)) / PER + 1;
        if (ns != 0 && c > ns) c = ns;
        return c % 256;
    endfunction

    task automatic tick();
        logic was;
        was = in_strobe;
        @(posedge CLK);
        #1;
        if (was && enable && !s_RST) sampled++;
        if (sampled >= SL) lat_cyc++;
        if (lat_cyc == 1) begin
            chk("latch_search_active", {a_sa, b_sa}, 2'b11);
            chk("latch_counter_val", {a_cval, b_cval}, {8'd95, 8'd95});
        end else if (lat_cyc == 2) begin
            chk("post_latch_search_active", {a_sa, b_sa}, 2'b00);
            chk("post_latch_sync_fail", {a_fail, b_fail}, {fail_a, fail_b});
            chk("post_latch_busy", {a_busy, b_busy}, 2'b11);
        end
    endtask

    task automatic chk_zero(string name);
        chk({name, "_a"}, {a_cval, a_sa, a_oi, a_oq, a_ostb, a_sst, a_idx, a_symc, a_fail, a_busy}, 0);
        chk({name, "_b"}, {b_cval, b_sa, b_oi, b_oq, b_ostb, b_sst, b_idx, b_symc, b_fail, b_busy}, 0);
    endtask

    // gmax < 0 selects a random gap of 0..3 idle cycles before each strobe.
    task automatic run(int pk, int ns, int nsamp, int gmax, bit rst_start, bit rst_end);
        int tgt_a, tgt_b, g, pa, pb;
        if (rst_start) begin
            s_RST = 1'b1; enable = 1'b0; in_strobe = 1'b0;
            tick();
            s_RST = 1'b0;
            chk_zero("after_reset");
        end
        peak_Index = 8'(pk);
        n_sym      = 8'(ns);
        sampled    = 0;
        lat_cyc    = 0;
        tgt_a  = pk + FFT + 1 + CP;
        tgt_b  = pk - 4 + FFT + 1 + CP;
        fail_a = (tgt_a < SL);
        fail_b = (pk < 4) || (tgt_b < SL);
        enable    = 1'b1;
        in_strobe = 1'b0;
        tick();
        for (int n = 0; n < nsamp; n++) begin
            g = (gmax < 0) ? int'($urandom_range(0, 3)) : gmax;
            // A strobe arriving in the latch cycle is consumed, so a target equal to it is lost.
            if (n == SL && g == 0) begin
                if (tgt_a == SL) fail_a = 1'b1;
                if (tgt_b == SL) fail_b = 1'b1;
            end
            for (int k = 0; k < g; k++) begin
                in_strobe = 1'b0;
                tick();
            end
            if (n == 120) n_sym = 8'($urandom);
            in_I = 16'($urandom);
            in_Q = 16'($urandom);
            in_strobe = 1'b1;
            pa = win_pos(n, tgt_a, fail_a, ns);
            pb = win_pos(n, tgt_b, fail_b, ns);
            if (pa >= 0) qa.push_back({in_I, in_Q, 6'(pa), pa == 0});
            if (pb >= 0) qb.push_back({in_I, in_Q, 6'(pb), pb == 0});
            tick();
        end
        in_strobe = 1'b0;
        tick();
        tick();
        chk("a_pending_outputs", qa.size(), 0);
        chk("b_pending_outputs", qb.size(), 0);
        chk("a_sym_count", a_symc, exp_sym(tgt_a, fail_a, nsamp, ns));
        chk("b_sym_count", b_symc, exp_sym(tgt_b, fail_b, nsamp, ns));
        chk("end_busy", {a_busy, b_busy}, 2'b11);
        chk("end_sync_fail", {a_fail, b_fail}, {fail_a && nsamp > SL, fail_b && nsamp > SL});
        qa.delete();
        qb.delete();
        if (rst_end) s_RST = 1'b1;
        else         enable = 1'b0;
        tick();
        s_RST = 1'b0;
        chk_zero(rst_end ? "after_mid_reset" : "after_enable_low");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        s_RST = 1'b1; enable = 1'b0; in_strobe = 1'b0;
        n_sym = 8'd0; peak_Index = 8'd0; in_I = 16'd0; in_Q = 16'd0;
        run(80, 0, 330, 0, 1, 0);   // continuous windows from sample 161
        run(10, 0, 150, 0, 1, 0);   // target 91 falls inside the search window
        run(2,  0, 150, 0, 0, 0);   // peak below correlator latency on the b instance
        run(84, 0, 330, 0, 1, 0);   // b instance first window at 161
        run(80, 2, 400, 0, 1, 0);   // exactly two symbols then DONE
        run(80, 0, 330, 2, 1, 0);   // strobe every third cycle
        run(15, 0, 200, 0, 1, 0);   // target == 96 lost to the latch-cycle strobe
        run(15, 0, 200, 1, 1, 0);   // target == 96 reachable when latch cycle is idle
        run(80, 0, 192, 0, 0, 0);   // drop enable at sample_idx 30
        run(80, 0, 40,  0, 0, 1);   // s_RST in the middle of the search
        run(80, 0, 330, -1, 0, 0);  // restart after reset with random gaps
        for (int r = 0; r < 4; r++)
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 420, -1, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
